dma_stream_engine: RTL and testbench

- Parametrised next-generation memory-to-memory DMA.
- Control slave, read master, write master and an internal credit-limited FIFO in one block; copies a block of words from a source to a destination address.
- Generalised in data width and FIFO depth over the previous fixed 32-bit engine.
- Adds byte length, busy/done status, abort and outstanding-read tracking; sits on the system bus as one slave plus two masters.

---
 rtl/dma_pkg.sv | 32 +++
 rtl/dma_sync_fifo.sv | 62 ++++++
 rtl/dma_stream_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_dma_stream_engine.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: register map, status/control bit positions and FSM encoding
// shared by dma_stream_engine, its FIFO and its testbench.
package dma_pkg;

  // Slave register word offsets
  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_RADDR   = 3'd1;
  localparam logic [2:0] REG_WADDR   = 3'd2;
  localparam logic [2:0] REG_LENGTH  = 3'd3;
  localparam logic [2:0] REG_CONTROL = 3'd4;

  // STATUS bits
  localparam int STATUS_DONE = 0;
  localparam int STATUS_BUSY = 1;

  // CONTROL bits (go and abort are self-clearing strobes)
  localparam int CTRL_GO     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ABORT  = 2;

  // FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Number of low address/length bits covered by one data word
  function automatic int bytes_shift(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// dma_sync_fifo: first-word-fall-through synchronous FIFO. Push and pop may
// occur together, also when full (the pop frees the slot being written).
// i_flush empties the FIFO and suppresses any push in the same cycle.
module dma_sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_data,
  input  logic                     i_pop,
  output logic [DW-1:0]            o_q,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_used
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_used;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_used == '0);
  assign o_full    = (r_used == (PW+1)'(DEPTH));
  assign o_used    = r_used;
  assign o_q       = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

  // Storage array: written on accepted push, no reset needed
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_used   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_used   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_used <= r_used + 1'b1;
        2'b01:   r_used <= r_used - 1'b1;
        default: r_used <= r_used;
      endcase
    end
  end

endmodule

// File: rtl/dma_stream_engine.sv
// dma_stream_engine: memory-to-memory DMA with a 32-bit control slave, a
// read master feeding a credit-limited FIFO, and a write master draining it.
// Optional feature macro: DMA_IRQ_EN (registered interrupt, irq_en bit).
// Handshake: a master request is taken on a cycle where request is high and
// waitrequest is low; request and address stay stable while waitrequest is
// high. Read data arrives in order, one word per iRM_readdatavalid pulse.
module dma_stream_engine
  import dma_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int LW         = 16
) (
  input  logic          iClk,
  input  logic          iReset_n,
  input  logic          iChipselect_n,
  input  logic          iRead,
  input  logic          iWrite,
  input  logic [2:0]    iAddress,
  input  logic [31:0]   iWritedata,
  output logic [31:0]   oReaddata,
  input  logic          iRM_waitrequest,
  input  logic          iRM_readdatavalid,
  input  logic [DW-1:0] iRM_readdata,
  output logic          oRM_read,
  output logic [AW-1:0] oRM_readaddress,
  input  logic          iWM_waitrequest,
  output logic          oWM_write,
  output logic [AW-1:0] oWM_writeaddress,
  output logic [DW-1:0] oWM_writedata,
  output logic          oIrq,
  output logic [1:0]    oDbg_state
);

  localparam int            BSH  = bytes_shift(DW);
  localparam int            CW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [AW-1:0] STEP = AW'(DW / 8);
  localparam logic [CW:0]   DEPTH_V = (CW+1)'(FIFO_DEPTH);

  logic [1:0]    r_state;
  logic          r_done;
  logic          r_busy;
  logic [AW-1:0] r_raddr;
  logic [AW-1:0] r_waddr;
  logic [LW-1:0] r_length;
  logic [AW-1:0] r_rd_addr;
  logic [AW-1:0] r_wr_addr;
  logic [LW-1:0] r_rd_cnt;
  logic [LW-1:0] r_wr_cnt;
  logic [CW-1:0] r_outstanding;
  logic [31:0]   r_readdata;

  logic          w_slv_wr;
  logic          w_slv_rd;
  logic          w_go;
  logic          w_abort;
  logic          w_status_wr;
  logic [LW-1:0] w_words;
  logic          w_irq_en;
  logic [DW-1:0] w_fifo_q;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic [CW-1:0] w_fifo_used;
  logic [CW:0]   w_inflight;
  logic          w_credit;
  logic          w_rd_accept;
  logic          w_rvalid;
  logic          w_push;
  logic          w_wr_accept;
  logic          w_flush;

  assign w_slv_wr    = ~iChipselect_n & iWrite;
  assign w_slv_rd    = ~iChipselect_n & iRead;
  assign w_go        = w_slv_wr & (iAddress == REG_CONTROL) & iWritedata[CTRL_GO];
  assign w_abort     = w_slv_wr & (iAddress == REG_CONTROL) & iWritedata[CTRL_ABORT];
  assign w_status_wr = w_slv_wr & (iAddress == REG_STATUS);
  assign w_words     = r_length >> BSH;

  // Credit counts both buffered words and words already requested
  assign w_inflight  = {1'b0, w_fifo_used} + {1'b0, r_outstanding};
  assign w_credit    = ~w_fifo_full & (w_inflight < DEPTH_V);

  assign oRM_read    = (r_state == ST_RUN) & (r_rd_cnt != '0) & w_credit;
  assign w_rd_accept = oRM_read & ~iRM_waitrequest;
  // Valids outside a transfer (e.g. after a reset) are stale and dropped
  assign w_rvalid    = iRM_readdatavalid & (r_outstanding != '0) &
                       ((r_state == ST_RUN) | (r_state == ST_DRAIN));
  assign w_push      = w_rvalid & (r_state == ST_RUN);
  assign w_flush     = (r_state == ST_DRAIN);

  assign oWM_write   = (r_state == ST_RUN) & ~w_fifo_empty & (r_wr_cnt != '0);
  assign w_wr_accept = oWM_write & ~iWM_waitrequest;

  assign oRM_readaddress  = r_rd_addr;
  assign oWM_writeaddress = r_wr_addr;
  assign oWM_writedata    = w_fifo_empty ? '0 : w_fifo_q;
  assign oReaddata        = r_readdata;
  assign oDbg_state       = r_state;

  dma_sync_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (iClk),
    .i_rst_n (iReset_n),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (iRM_readdata),
    .i_pop   (w_wr_accept),
    .o_q     (w_fifo_q),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_used  (w_fifo_used)
  );

  // Transfer FSM
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_go) r_state <= (w_words == '0) ? ST_DONE : ST_RUN;
        ST_RUN:   if (w_abort) r_state <= ST_DRAIN;
                  else if (r_wr_cnt == '0) r_state <= ST_DONE;
        ST_DRAIN: if (r_outstanding == '0) r_state <= ST_DONE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Working addresses and word counters for both masters
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
    end else if ((r_state == ST_IDLE) && w_go) begin
      r_rd_addr <= r_raddr;
      r_wr_addr <= r_waddr;
      r_rd_cnt  <= w_words;
      r_wr_cnt  <= w_words;
    end else begin
      if (w_rd_accept) begin
        r_rd_addr <= r_rd_addr + STEP;
        r_rd_cnt  <= r_rd_cnt - 1'b1;
      end
      if (w_wr_accept) begin
        r_wr_addr <= r_wr_addr + STEP;
        r_wr_cnt  <= r_wr_cnt - 1'b1;
      end
    end
  end

  // Outstanding reads: accepted requests not yet returned
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_outstanding <= '0;
    end else begin
      case ({w_rd_accept, w_rvalid})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Status flags: DONE state wins over a simultaneous STATUS write
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_done <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      if (w_status_wr) r_done <= 1'b0;
      if ((r_state == ST_IDLE) && w_go) r_busy <= 1'b1;
    end
  end

  // Configuration registers, frozen while a transfer is active
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_raddr  <= '0;
      r_waddr  <= '0;
      r_length <= '0;
    end else if (w_slv_wr && !r_busy) begin
      case (iAddress)
        REG_RADDR:  r_raddr  <= iWritedata[AW-1:0];
        REG_WADDR:  r_waddr  <= iWritedata[AW-1:0];
        REG_LENGTH: r_length <= iWritedata[LW-1:0];
        default:    ;
      endcase
    end
  end

  // Registered slave read data, updated only on a read strobe
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_readdata <= '0;
    end else if (w_slv_rd) begin
      case (iAddress)
        REG_STATUS:  r_readdata <= {30'b0, r_busy, r_done};
        REG_RADDR:   r_readdata <= 32'(r_raddr);
        REG_WADDR:   r_readdata <= 32'(r_waddr);
        REG_LENGTH:  r_readdata <= 32'(r_length);
        REG_CONTROL: r_readdata <= {29'b0, 1'b0, w_irq_en, 1'b0};
        default:     r_readdata <= '0;
      endcase
    end
  end

`ifdef DMA_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  // Interrupt enable bit, writable at any time
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_irq_en <= 1'b0;
    end else if (w_slv_wr && (iAddress == REG_CONTROL)) begin
      r_irq_en <= iWritedata[CTRL_IRQ_EN];
    end
  end

  // Interrupt follows done one cycle later; a STATUS write drops it at once
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_irq <= 1'b0;
    end else if (w_status_wr) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_done & r_irq_en;
    end
  end

  assign w_irq_en = r_irq_en;
  assign oIrq     = r_irq;
`else
  assign w_irq_en = 1'b0;
  assign oIrq     = 1'b0;
`endif

endmodule

// File: tb/tb_dma_stream_engine.sv
// tb_dma_stream_engine: directed scoreboard bench for dma_stream_engine.
// A bus model answers the read master from a synthetic memory and checks
// every read request and write against queues filled when a transfer starts.
`timescale 1ns/1ps
module tb_dma_stream_engine;
  import dma_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int FD = 4;
  localparam int LW = 16;

  logic          iClk = 1'b0;
  logic          iReset_n;
  logic          iChipselect_n;
  logic          iRead;
  logic          iWrite;
  logic [2:0]    iAddress;
  logic [31:0]   iWritedata;
  logic [31:0]   oReaddata;
  logic          iRM_waitrequest;
  logic          iRM_readdatavalid;
  logic [DW-1:0] iRM_readdata;
  logic          oRM_read;
  logic [AW-1:0] oRM_readaddress;
  logic          iWM_waitrequest;
  logic          oWM_write;
  logic [AW-1:0] oWM_writeaddress;
  logic [DW-1:0] oWM_writedata;
  logic          oIrq;
  logic [1:0]    oDbg_state;

  // ---------------- clock / reset ----------------
  always #5 iClk = ~iClk;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  dma_stream_engine #(
    .DW(DW), .AW(AW), .FIFO_DEPTH(FD), .LW(LW)
  ) dut (
    .iClk              (iClk),
    .iReset_n          (iReset_n),
    .iChipselect_n     (iChipselect_n),
    .iRead             (iRead),
    .iWrite            (iWrite),
    .iAddress          (iAddress),
    .iWritedata        (iWritedata),
    .oReaddata         (oReaddata),
    .iRM_waitrequest   (iRM_waitrequest),
    .iRM_readdatavalid (iRM_readdatavalid),
    .iRM_readdata      (iRM_readdata),
    .oRM_read          (oRM_read),
    .oRM_readaddress   (oRM_readaddress),
    .iWM_waitrequest   (iWM_waitrequest),
    .oWM_write         (oWM_write),
    .oWM_writeaddress  (oWM_writeaddress),
    .oWM_writedata     (oWM_writedata),
    .oIrq              (oIrq),
    .oDbg_state        (oDbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_raddr_q[$];
  logic [31:0] exp_waddr_q[$];
  logic [31:0] exp_wdata_q[$];

  typedef struct {
    logic [31:0] data;
    int          ready;
  } resp_t;
  resp_t resp_q[$];

  int cyc           = 0;
  bit rand_rd       = 1'b0;
  bit rand_wr       = 1'b0;
  int accept_budget = -1;
  int release_budget = -1;
  int wm_hold       = 0;
  int n_accepts     = 0;
  int n_writes      = 0;
  int n_req_cycles  = 0;
  int n_wreq_cycles = 0;
  int max_inflight  = 0;
  bit prev_stall    = 1'b0;
  logic [31:0] prev_raddr = '0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- bus model (read slave + write sink) ----------------
  initial begin : bus_model
    int d;
    int inflight;
    iRM_waitrequest   = 1'b0;
    iRM_readdatavalid = 1'b0;
    iRM_readdata      = '0;
    iWM_waitrequest   = 1'b0;
    forever begin
      @(negedge iClk);
      cyc++;
      // in-order read data return
      iRM_readdatavalid = 1'b0;
      if (resp_q.size() != 0 && resp_q[0].ready <= cyc && release_budget != 0) begin
        iRM_readdata      = resp_q[0].data;
        iRM_readdatavalid = 1'b1;
        resp_q.delete(0);
        if (release_budget > 0) release_budget--;
      end
      // a stalled request must keep its address
      if (prev_stall && oRM_read) check("raddr_hold", oRM_readaddress, prev_raddr);
      if (accept_budget == 0)  iRM_waitrequest = 1'b1;
      else if (rand_rd)        iRM_waitrequest = ($urandom_range(0, 2) == 0);
      else                     iRM_waitrequest = 1'b0;
      if (oRM_read) n_req_cycles++;
      if (oRM_read && !iRM_waitrequest) begin
        n_accepts++;
        if (accept_budget > 0) accept_budget--;
        check("rd_expected", 32'(exp_raddr_q.size() != 0), 32'd1);
        if (exp_raddr_q.size() != 0) check("raddr", oRM_readaddress, exp_raddr_q.pop_front());
        d = rand_rd ? int'($urandom_range(1, 5)) : 1;
        resp_q.push_back('{data: mem_data(oRM_readaddress), ready: cyc + d});
      end
      prev_stall = oRM_read && iRM_waitrequest;
      prev_raddr = oRM_readaddress;
      // write sink
      if (wm_hold > 0) begin
        iWM_waitrequest = 1'b1;
        wm_hold--;
      end else if (rand_wr) iWM_waitrequest = ($urandom_range(0, 1) == 0);
      else                  iWM_waitrequest = 1'b0;
      if (oWM_write) n_wreq_cycles++;
      if (oWM_write && !iWM_waitrequest) begin
        n_writes++;
        check("wr_expected", 32'(exp_waddr_q.size() != 0), 32'd1);
        if (exp_waddr_q.size() != 0) begin
          check("waddr", oWM_writeaddress, exp_waddr_q.pop_front());
          check("wdata", oWM_writedata, exp_wdata_q.pop_front());
        end
      end
      inflight = n_accepts - n_writes;
      if (inflight > max_inflight) max_inflight = inflight;
    end
  end

  // ---------------- slave driver tasks ----------------
  task automatic reg_write(input logic [2:0] a, input logic [31:0] v);
    @(negedge iClk);
    iChipselect_n = 1'b0; iWrite = 1'b1; iAddress = a; iWritedata = v;
    @(negedge iClk);
    iChipselect_n = 1'b1; iWrite = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] v);
    @(negedge iClk);
    iChipselect_n = 1'b0; iRead = 1'b1; iAddress = a;
    @(negedge iClk);
    iChipselect_n = 1'b1; iRead = 1'b0;
    v = oReaddata;
  endtask

  task automatic start_xfer(input logic [31:0] ra, input logic [31:0] wa,
                            input logic [31:0] len, input logic [31:0] ctrl_extra);
    int words;
    reg_write(REG_STATUS, 32'h0);
    reg_write(REG_RADDR, ra);
    reg_write(REG_WADDR, wa);
    reg_write(REG_LENGTH, len);
    words = int'(len[LW-1:0]) >> 2;
    for (int i = 0; i < words; i++) begin
      exp_raddr_q.push_back(ra + 32'(4 * i));
      exp_waddr_q.push_back(wa + 32'(4 * i));
      exp_wdata_q.push_back(mem_data(ra + 32'(4 * i)));
    end
    n_accepts = 0; n_writes = 0; n_req_cycles = 0; n_wreq_cycles = 0; max_inflight = 0;
    reg_write(REG_CONTROL, 32'h1 | ctrl_extra);
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < 1000; k++) begin
      reg_read(REG_STATUS, s);
      if (s[STATUS_DONE]) break;
    end
    check(tag, s, 32'h1);
  endtask

  task automatic check_drained(input string tag, input int words);
    check({tag, "_nwrites"}, 32'(n_writes), 32'(words));
    check({tag, "_rdq_empty"}, 32'(exp_raddr_q.size()), 32'd0);
    check({tag, "_wrq_empty"}, 32'(exp_waddr_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [31:0] d;
    iChipselect_n = 1'b1; iRead = 1'b0; iWrite = 1'b0; iAddress = '0; iWritedata = '0;
    iReset_n = 1'b0;
    repeat (3) @(negedge iClk);
    check("rst_rm_read",   32'(oRM_read), 32'd0);
    check("rst_wm_write",  32'(oWM_write), 32'd0);
    check("rst_wdata",     oWM_writedata, 32'd0);
    check("rst_irq",       32'(oIrq), 32'd0);
    check("rst_readdata",  oReaddata, 32'd0);
    check("rst_state",     32'(oDbg_state), 32'(ST_IDLE));
    iReset_n = 1'b1;
    @(negedge iClk);
    reg_read(REG_STATUS, d);  check("rst_status", d, 32'h0);
    reg_read(REG_LENGTH, d);  check("rst_length", d, 32'h0);

    // 1: basic 4-word copy
    start_xfer(32'h1000, 32'h2000, 32'd16, 32'h0);
    wait_done("t1_done");
    check_drained("t1", 4);
    reg_read(REG_RADDR, d);   check("t1_raddr_rb", d, 32'h1000);
    reg_read(REG_LENGTH, d);  check("t1_len_rb", d, 32'd16);
    reg_read(3'd5, d);        check("t1_reg5_zero", d, 32'h0);

    // 2: zero length finishes without bus traffic
    start_xfer(32'h5000, 32'h6000, 32'd0, 32'h0);
    reg_read(REG_STATUS, d);  check("t2_done_fast", d, 32'h1);
    repeat (4) @(negedge iClk);
    check("t2_no_read",  32'(n_req_cycles), 32'd0);
    check("t2_no_write", 32'(n_wreq_cycles), 32'd0);

    // 3: write stall fills the FIFO; credit must cap in-flight words
    wm_hold = 50;
    start_xfer(32'h0001_0000, 32'h0002_0000, 32'd128, 32'h0);
    repeat (10) @(negedge iClk);
    reg_read(REG_STATUS, d);  check("t3_busy", d, 32'h2);
    reg_write(REG_RADDR, 32'hDEAD_0000);
    reg_read(REG_RADDR, d);   check("t3_raddr_frozen", d, 32'h0001_0000);
    wait_done("t3_done");
    check_drained("t3", 32);
    check("t3_credit_max", 32'(max_inflight), 32'(FD));

    // 4: random stalls and read latency, both address ranges wrap
    rand_rd = 1'b1; rand_wr = 1'b1;
    start_xfer(32'hFFFF_FFC0, 32'hFFFF_FFF0, 32'd128, 32'h0);
    wait_done("t4_done");
    check_drained("t4", 32);
    rand_rd = 1'b0; rand_wr = 1'b0;

    // 5: abort with 3 words written and 2 reads outstanding
    accept_budget = 5; release_budget = 3;
    start_xfer(32'h7000, 32'h8000, 32'd32, 32'h0);
    for (int k = 0; k < 300 && !(n_writes == 3 && n_accepts == 5); k++) @(negedge iClk);
    repeat (2) @(negedge iClk);
    check("t5_pre_writes",  32'(n_writes), 32'd3);
    check("t5_pre_accepts", 32'(n_accepts), 32'd5);
    reg_write(REG_CONTROL, 32'h4);
    check("t5_drain", 32'(oDbg_state), 32'(ST_DRAIN));
    repeat (5) @(negedge iClk);
    check("t5_drain_hold", 32'(oDbg_state), 32'(ST_DRAIN));
    release_budget = -1; accept_budget = -1;
    wait_done("t5_done");
    check("t5_writes_after", 32'(n_writes), 32'd3);
    check("t5_accepts_after", 32'(n_accepts), 32'd5);
    check("t5_resp_empty", 32'(resp_q.size()), 32'd0);
    exp_raddr_q.delete(); exp_waddr_q.delete(); exp_wdata_q.delete();
    start_xfer(32'h3000, 32'h4000, 32'd16, 32'h0);
    wait_done("t5_next_done");
    check_drained("t5_next", 4);

    // 6: interrupt
`ifdef DMA_IRQ_EN
    start_xfer(32'h9000, 32'hA000, 32'd16, 32'h2);
    for (int k = 0; k < 300 && oDbg_state != ST_DONE; k++) @(negedge iClk);
    check("t6_reach_done", 32'(oDbg_state), 32'(ST_DONE));
    @(negedge iClk);
    check("t6_irq_not_yet", 32'(oIrq), 32'd0);
    @(negedge iClk);
    check("t6_irq_high", 32'(oIrq), 32'd1);
    reg_read(REG_CONTROL, d); check("t6_ctrl_rb", d, 32'h2);
    reg_write(REG_STATUS, 32'h0);
    check("t6_irq_cleared", 32'(oIrq), 32'd0);
    reg_read(REG_STATUS, d);  check("t6_status_cleared", d, 32'h0);
    check_drained("t6", 4);
`else
    start_xfer(32'h9000, 32'hA000, 32'd16, 32'h2);
    wait_done("t6_done");
    repeat (3) @(negedge iClk);
    check("t6_irq_tied", 32'(oIrq), 32'd0);
    reg_read(REG_CONTROL, d); check("t6_ctrl_rb", d, 32'h0);
    check_drained("t6", 4);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
